// File: rtl/dataflow_pkg.sv
// ============================================================================
//  Module      : dataflow_pkg
//  Description : Shared types for the dataflow index stream block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dataflow_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

endpackage : dataflow_pkg

`default_nettype wire

// File: rtl/dataflow_index_next.sv
// ============================================================================
//  Module      : dataflow_index_next
//  Description : Combinational next-index adder and last-index detection.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dataflow_index_next #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] cur_idx,
   input  logic [WIDTH-1:0] step,
   input  logic [WIDTH-1:0] bound,
   output logic [WIDTH-1:0] next_idx,
   output logic             last
);

   logic [WIDTH:0] sum;

   // The extra carry bit ends the sequence instead of letting the index wrap.
   always_comb begin
      sum      = {1'b0, cur_idx} + {1'b0, step};
      next_idx = sum[WIDTH-1:0];
      last     = sum[WIDTH] | (sum[WIDTH-1:0] >= bound);
   end

endmodule : dataflow_index_next

`default_nettype wire

// File: rtl/dataflow_index_stream.sv
// ============================================================================
//  Module      : dataflow_index_stream
//  Description : Expands a (start, step, bound) loop descriptor into a
//                ready/valid stream of indices, one per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dataflow_index_stream
   import dataflow_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [WIDTH-1:0] cfg_start,
   input  logic [WIDTH-1:0] cfg_step,
   input  logic [WIDTH-1:0] cfg_bound,
   output logic             idx_valid,
   input  logic             idx_ready,
   output logic [WIDTH-1:0] idx_data,
   output logic             idx_last,
   output logic             busy
);

   state_e           state_q,    state_d;
   logic [WIDTH-1:0] idx_data_q, idx_data_d;
   logic [WIDTH-1:0] step_q,     step_d;
   logic [WIDTH-1:0] bound_q,    bound_d;

   logic [WIDTH-1:0] next_idx;
   logic             next_last;

   dataflow_index_next #(
      .WIDTH (WIDTH)
   ) u_next (
      .cur_idx  (idx_data_q),
      .step     (step_q),
      .bound    (bound_q),
      .next_idx (next_idx),
      .last     (next_last)
   );

   always_comb begin
      state_d    = state_q;
      idx_data_d = idx_data_q;
      step_d     = step_q;
      bound_d    = bound_q;
      unique case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               step_d  = cfg_step;
               bound_d = cfg_bound;
               // Empty ranges and zero steps are consumed without output.
               if ((cfg_step != '0) && (cfg_start < cfg_bound)) begin
                  idx_data_d = cfg_start;
                  state_d    = RUN;
               end
            end
         end
         RUN: begin
            if (idx_ready) begin
               if (next_last) begin
                  state_d = IDLE;
               end else begin
                  idx_data_d = next_idx;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_data_q <= '0;
         step_q     <= '0;
         bound_q    <= '0;
      end else begin
         state_q    <= state_d;
         idx_data_q <= idx_data_d;
         step_q     <= step_d;
         bound_q    <= bound_d;
      end
   end

   assign cfg_ready = (state_q == IDLE);
   assign busy      = (state_q == RUN);
   assign idx_valid = (state_q == RUN);
   assign idx_data  = idx_data_q;
   assign idx_last  = (state_q == RUN) & next_last;

endmodule : dataflow_index_stream

`default_nettype wire

// File: doc/dataflow_index_stream.md
DATAFLOW_INDEX_STREAM -- requirements
Module: dataflow_index_stream

Interface
REQ-001 Parameter WIDTH, default 64, sets the bit width of start, step, bound and index values; legal values are 1 to 64.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  is the reset; it is synchronous and active-high.
REQ-004 cfg_valid  input  1  indicates a loop descriptor is offered.
REQ-005 cfg_ready  output  1  indicates the block accepts a descriptor this cycle.
REQ-006 cfg_start  input  WIDTH  is the first index, unsigned.
REQ-007 cfg_step  input  WIDTH  is the increment, unsigned.
REQ-008 cfg_bound  input  WIDTH  is the exclusive upper bound, unsigned.
REQ-009 idx_valid  output  1  indicates idx_data holds a valid index.
REQ-010 idx_ready  input  1  is backpressure from the downstream consumer (the index-cast stage).
REQ-011 idx_data  output  WIDTH  is the current index.
REQ-012 idx_last  output  1  marks the final index of the descriptor; it is qualified by idx_valid.
REQ-013 busy  output  1  is high while a descriptor is being emitted.

Function
REQ-014 The block SHALL have exactly two states: IDLE and RUN.
REQ-015 In IDLE: cfg_ready=1, idx_valid=0, busy=0. In RUN: cfg_ready=0, busy=1.
REQ-016 A descriptor handshake (cfg_valid&&cfg_ready) in IDLE with cfg_step!=0 and cfg_start<cfg_bound SHALL move the block to RUN and register idx_data=cfg_start; idx_valid rises the next cycle, so latency is 1 cycle.
REQ-017 A descriptor with cfg_step==0 or cfg_start>=cfg_bound SHALL be accepted, emit no index, and leave the block in IDLE.
REQ-018 An index transfers on idx_valid&&idx_ready; without it, idx_data, idx_last and idx_valid SHALL hold stable.
REQ-019 next = idx_data+cfg_step is computed at WIDTH+1 bits; idx_last SHALL be 1 when the carry bit is set or next[WIDTH-1:0]>=bound.
REQ-020 On a transfer with idx_last=0, idx_data SHALL become next[WIDTH-1:0] in the following cycle, with idx_valid staying high, so throughput is 1 index per cycle.
REQ-021 On a transfer with idx_last=1, the block SHALL return to IDLE and idx_valid SHALL drop the next cycle; cfg_ready is high in that same cycle, which gives a one-cycle bubble between descriptors.
REQ-022 Wrap-around SHALL never produce an index: an unsigned carry out of the add terminates the sequence.
REQ-023 Step and bound SHALL be latched at the handshake; cfg_* changes during RUN are ignored.

Reset
REQ-024 While rst=1, the block SHALL be in IDLE with idx_valid=0, idx_last=0, idx_data=0 and busy=0, effective at the next clock edge.
REQ-025 Reset asserted during RUN SHALL abandon the sequence with no further index; cfg_ready=1 in the first cycle after rst deasserts.

Structure
REQ-026 The state enum (IDLE, RUN) SHALL be defined in the shared package dataflow_pkg.
REQ-027 A sub-module dataflow_index_next SHALL compute the WIDTH+1-bit sum and the last flag combinationally; the top level holds the registers and the FSM.

Verification
REQ-028 WIDTH=64, start=0, step=1, bound=4, idx_ready=1 -> idx_data 0,1,2,3 on consecutive cycles, idx_last only on 3, idle 1 cycle later.
REQ-029 start=2, step=3, bound=10, idx_ready toggling 1/0 -> exactly 2,5,8 with last on 8; values stable during stall cycles.
REQ-030 WIDTH=8, start=250, step=4, bound=255 -> 250, then 254 with last=1 (258 carries); no wrapped value emitted.
REQ-031 start=5, bound=5, step=1; then step=0 -> both accepted, zero indices, cfg_ready stays 1.
REQ-032 rst pulsed after the second index of start=0, step=1, bound=100 -> idx_valid=0 the next cycle; a new descriptor start=7, step=1, bound=8 emits only 7 with last.
REQ-033 Two back-to-back descriptors held on cfg_valid -> the second is accepted the cycle after the first descriptor's last transfer.
